// File: rtl/activity_pkg.sv
// Shared constants for the activity monitor: FSM state encoding and default
// parameter values used by the monitor top level.
package activity_pkg;

    localparam int DEF_CLK_HZ      = 100000000;
    localparam int DEF_HIGH_THRESH = 64;
    localparam int DEF_STEP_W      = 20;
    localparam int DEF_RATE_W      = 10;
    localparam int DEF_SEC_W       = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/step_edge_sync.sv
// Brings the raw step input into the clk100MHz domain and turns each rising
// edge into a single-cycle registered pulse.
module step_edge_sync (
    input  logic clk100MHz,
    input  logic reset,
    input  logic X,
    output logic step_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_pulse;

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= X;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_pulse <= r_sync2 & ~r_sync3;
        end
    end

    assign step_pulse = r_pulse;

endmodule

// File: rtl/high_activity_monitor.sv
// Counts steps per one-second window and tracks how many windows, and how many
// consecutive windows, reached the high-activity threshold.
module high_activity_monitor
    import activity_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int HIGH_THRESH = DEF_HIGH_THRESH,
    parameter int STEP_W      = DEF_STEP_W,
    parameter int RATE_W      = DEF_RATE_W,
    parameter int SEC_W       = DEF_SEC_W
) (
    input  logic              clk100MHz,
    input  logic              reset,
    input  logic              X,
    input  logic              enable,
    input  logic              clear,
    output logic [STEP_W-1:0] total_steps,
    output logic [RATE_W-1:0] steps_last_sec,
    output logic [SEC_W-1:0]  high_activity_seconds,
    output logic [SEC_W-1:0]  cur_streak,
    output logic [SEC_W-1:0]  max_streak,
    output logic              sec_tick,
    output logic [1:0]        dbg_state
);

    localparam int                TMR_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(CLK_HZ - 1);
    localparam logic [RATE_W-1:0] THRESH   = RATE_W'(HIGH_THRESH);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [TMR_W-1:0]  r_timer;
    logic [RATE_W-1:0] r_rate;
    logic [STEP_W-1:0] r_total;
    logic [RATE_W-1:0] r_last;
    logic [SEC_W-1:0]  r_high_secs;
    logic [SEC_W-1:0]  r_cur;
    logic [SEC_W-1:0]  r_max;

    logic              w_step_pulse;
    logic              w_run;
    logic              w_step;
    logic              w_tick;
    logic [RATE_W-1:0] w_rate_close;
    logic              w_high;
    logic [SEC_W-1:0]  w_streak_next;

    step_edge_sync u_sync (
        .clk100MHz (clk100MHz),
        .reset     (reset),
        .X         (X),
        .step_pulse(w_step_pulse)
    );

    assign w_run  = (r_state == ST_RUN);
    assign w_step = w_run & w_step_pulse;
    assign w_tick = w_run & (r_timer == TMR_LAST);

    // The closing count includes a step landing on the tick cycle itself.
    assign w_rate_close  = (w_step && (r_rate != '1)) ? r_rate + RATE_W'(1) : r_rate;
    assign w_high        = (w_rate_close >= THRESH);
    assign w_streak_next = w_high ? ((r_cur == '1) ? r_cur : r_cur + SEC_W'(1)) : '0;

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (enable)  w_state_next = ST_RUN;
                ST_RUN:  if (!enable) w_state_next = ST_HOLD;
                ST_HOLD: if (enable)  w_state_next = ST_RUN;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_rate      <= '0;
            r_total     <= '0;
            r_last      <= '0;
            r_high_secs <= '0;
            r_cur       <= '0;
            r_max       <= '0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_rate      <= '0;
            r_total     <= '0;
            r_last      <= '0;
            r_high_secs <= '0;
            r_cur       <= '0;
            r_max       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_step && (r_total != '1)) begin
                r_total <= r_total + STEP_W'(1);
            end
            if (w_tick) begin
                r_timer <= '0;
                r_rate  <= '0;
                r_last  <= w_rate_close;
                r_cur   <= w_streak_next;
                if (w_high && (r_high_secs != '1)) begin
                    r_high_secs <= r_high_secs + SEC_W'(1);
                end
                if (w_streak_next > r_max) begin
                    r_max <= w_streak_next;
                end
            end else if (w_run) begin
                r_timer <= r_timer + TMR_W'(1);
                r_rate  <= w_rate_close;
            end
        end
    end

    // A threshold the rate counter cannot represent would silently truncate.
    always_ff @(posedge clk100MHz) begin
        assert ((HIGH_THRESH < (2 ** RATE_W)) && (CLK_HZ >= 4))
            else $error("high_activity_monitor: HIGH_THRESH exceeds RATE_W range or CLK_HZ < 4");
    end

    assign total_steps           = r_total;
    assign steps_last_sec        = r_last;
    assign high_activity_seconds = r_high_secs;
    assign cur_streak            = r_cur;
    assign max_streak            = r_max;
    assign sec_tick              = w_tick;
    assign dbg_state             = r_state;

endmodule

// File: doc/high_activity_monitor.md
HIGH_ACTIVITY_MONITOR -- requirements
Module: high_activity_monitor

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clk100MHz cycles per one-second window; minimum 4.
REQ-002 Parameter HIGH_THRESH, default 64: minimum steps in one window for that second to count as high-activity.
REQ-003 Parameter STEP_W, default 20: width of the total-step counter.
REQ-004 Parameter RATE_W, default 10: width of the per-second step counter.
REQ-005 Parameter SEC_W, default 7: width of the seconds and streak counters.
REQ-006 clk100MHz  input  1  system clock, rising-edge active.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 X  input  1  raw asynchronous step pulse; one rising edge is one step.
REQ-009 enable  input  1  high runs the monitor; low pauses it.
REQ-010 clear  input  1  synchronous clear of all counters.
REQ-011 total_steps  output  STEP_W  cumulative steps, saturating.
REQ-012 steps_last_sec  output  RATE_W  step count of the most recently closed window.
REQ-013 high_activity_seconds  output  SEC_W  count of closed windows with at least HIGH_THRESH steps, saturating.
REQ-014 cur_streak  output  SEC_W  consecutive high windows ending at the last closed window, saturating.
REQ-015 max_streak  output  SEC_W  largest cur_streak value since reset or clear.
REQ-016 sec_tick  output  1  one-cycle pulse when a window closes; all window outputs update in the same cycle.

Function
REQ-017 X shall pass through a 2-flop synchronizer, then a registered rising-edge detect; a step is counted on the 3rd rising clock edge after the first edge that samples X high.
REQ-018 The FSM shall have states IDLE, RUN and HOLD; reset and clear enter IDLE.
REQ-019 IDLE->RUN on enable=1; RUN->HOLD on enable=0; HOLD->RUN on enable=1; no other transitions.
REQ-020 In IDLE and HOLD, steps shall be ignored, the window timer frozen and partial window counts retained.
REQ-021 In RUN, the window timer counts 0..CLK_HZ-1; sec_tick pulses in the cycle the timer equals CLK_HZ-1, then the timer wraps to 0.
REQ-022 In RUN, each step increments total_steps and the window rate counter; both saturate at all-ones.
REQ-023 A step coincident with sec_tick belongs to the closing window; the rate counter restarts at 0 in the next cycle.
REQ-024 At sec_tick, steps_last_sec takes the closing window count including any coincident step.
REQ-025 At sec_tick, if that count >= HIGH_THRESH, high_activity_seconds and cur_streak increment (saturating); otherwise cur_streak goes to 0.
REQ-026 max_streak shall update to the post-tick cur_streak whenever it exceeds the current max_streak, in the same cycle.
REQ-027 The comparison shall be unsigned at RATE_W width; HIGH_THRESH wider than RATE_W allows is a configuration error, flagged by a simulation assertion.
REQ-028 If clear and enable are both high, clear wins; the FSM goes to IDLE and reaches RUN no earlier than the next cycle.
REQ-029 A sec_tick cycle in which enable falls shall complete the window; HOLD is entered in the next cycle.

Reset
REQ-030 Asserting reset shall immediately zero all outputs, the counters, the timer and the synchronizer flops, and force the FSM to IDLE.
REQ-031 Reset release is synchronous to clk100MHz; the first step can be counted no earlier than 3 cycles after release.
REQ-032 Reset mid-window shall discard the partial window with no sec_tick.

Structure
REQ-033 FSM state encoding and default parameter constants shall live in shared package activity_pkg.
REQ-034 The synchronizer and edge detect shall be the sub-module step_edge_sync, with ports clk100MHz, reset, X and step_pulse.
REQ-035 The block shall contain no latches and use no clock other than clk100MHz.

Verification (CLK_HZ=16, HIGH_THRESH=3, RATE_W=4, SEC_W=3)
REQ-036 Reset, enable=1, 4 steps in window 1 -> sec_tick at cycle 16 of RUN; steps_last_sec=4, high_activity_seconds=1, cur_streak=1, max_streak=1.
REQ-037 Windows with 3, 3, 1 and 3 steps -> high_activity_seconds=3, cur_streak sequence 1,2,0,1, max_streak=2.
REQ-038 Step edge on the sec_tick cycle in a window already holding 2 steps -> steps_last_sec=3, counted high; the next window starts at 0.
REQ-039 20 steps in one window -> steps_last_sec saturates at 15; 9 consecutive high windows -> cur_streak and high_activity_seconds hold at 7.
REQ-040 enable low for 10 cycles mid-window with X toggling -> no steps counted; the timer resumes, so sec_tick is delayed by exactly 10 cycles.
REQ-041 reset pulse mid-window, and separately clear=1 with enable=1 -> all outputs 0, no sec_tick, RUN re-entered only after a later enable.
